// File: rtl/veri_pd_pkg.sv
// Shared definitions for the phase-detector vote filter: default sizing,
// counter widths and the majority-vote decision helper.
package veri_pd_pkg;

    localparam int NLANE_DEF    = 16;
    localparam int WIN_DEF      = 8;
    localparam int LOCK_CNT_DEF = 4;

    // A vote count must hold WIN itself, an alternation count must hold LOCK_CNT
    localparam int VCNT_W = $clog2(WIN_DEF + 1);
    localparam int ALT_W  = $clog2(LOCK_CNT_DEF + 1);

    typedef enum logic [1:0] {
        VOTE_ZERO = 2'd0,
        VOTE_ONE  = 2'd1,
        VOTE_TIE  = 2'd2
    } vote_e;

    // Majority decision for a completed window: exactly half is a tie
    function automatic vote_e vote_decide(input int ones, input int win);
        if (ones * 2 > win) begin
            return VOTE_ONE;
        end else if (ones * 2 < win) begin
            return VOTE_ZERO;
        end else begin
            return VOTE_TIE;
        end
    endfunction

endpackage

// File: rtl/veri_pd_lane_vote.sv
// One lane of the vote filter: accumulates the lane's ones over a window,
// resolves the majority at the last sample and tracks dither/lock state.
module veri_pd_lane_vote
    import veri_pd_pkg::*;
#(
    parameter int WIN      = WIN_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int VW       = VCNT_W,
    parameter int AW       = ALT_W
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sample,
    input  logic i_last,
    input  logic i_raw,
    input  logic i_freeze_clr,
    output logic o_pd_out,
    output logic o_freeze
);

    logic [VW-1:0] r_vcnt;
    logic [AW-1:0] r_alt;
    logic          r_pd_out;
    logic          r_freeze;

    logic [VW-1:0] w_ones;
    logic [AW-1:0] w_alt_inc;
    vote_e         w_vote;
    logic          w_dec;
    logic          w_tie;

    // Window total including the current sample, and the saturating alternation step
    always_comb begin
        w_ones    = r_vcnt + VW'(i_raw);
        w_vote    = vote_decide(int'(w_ones), WIN);
        w_tie     = (w_vote == VOTE_TIE);
        w_dec     = (w_vote == VOTE_ONE);
        w_alt_inc = (r_alt == AW'(LOCK_CNT)) ? r_alt : r_alt + AW'(1);
    end

    // Vote accumulation, decision update and lock tracking; freeze_clr wins over a set
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vcnt   <= '0;
            r_alt    <= '0;
            r_pd_out <= 1'b0;
            r_freeze <= 1'b0;
        end else begin
            if (i_sample) begin
                if (i_last) begin
                    r_vcnt <= '0;
                    if (!w_tie) begin
                        if (w_dec != r_pd_out) begin
                            r_pd_out <= w_dec;
                            r_alt    <= w_alt_inc;
                            if (w_alt_inc == AW'(LOCK_CNT)) begin
                                r_freeze <= 1'b1;
                            end
                        end else begin
                            r_alt    <= '0;
                            r_freeze <= 1'b0;
                        end
                    end
                end else begin
                    r_vcnt <= w_ones;
                end
            end
            if (i_freeze_clr) begin
                r_alt    <= '0;
                r_freeze <= 1'b0;
            end
        end
    end

    assign o_pd_out = r_pd_out;
    assign o_freeze = r_freeze;

endmodule

// File: rtl/veri_pd_vote_filter.sv
// Majority-vote filter for raw per-lane bang-bang PD decisions. Holds the shared
// window counter and completion pulse; per-lane state lives in the lane instances.
module veri_pd_vote_filter
    import veri_pd_pkg::*;
#(
    parameter int NLANE    = NLANE_DEF,
    parameter int WIN      = WIN_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_pd_valid,
    input  logic [NLANE-1:0] i_pd_raw,
    input  logic             i_freeze_clr,
    output logic [NLANE-1:0] o_pd_out,
    output logic [NLANE-1:0] o_freeze,
    output logic             o_win_done,
    output logic             o_locked_all
);

    localparam int WCNT_W = $clog2(WIN);
    localparam int LVW    = $clog2(WIN + 1);
    localparam int LAW    = $clog2(LOCK_CNT + 1);

    logic [WCNT_W-1:0] r_wcnt;
    logic              r_win_done;
    logic              w_sample;
    logic              w_last;

    // A sample only counts when both enable and valid are high
    always_comb begin
        w_sample = i_enable & i_pd_valid;
        w_last   = w_sample & (r_wcnt == WCNT_W'(WIN - 1));
    end

    // Shared sample index within the window and the one-cycle completion pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wcnt     <= '0;
            r_win_done <= 1'b0;
        end else begin
            r_win_done <= w_last;
            if (w_last) begin
                r_wcnt <= '0;
            end else if (w_sample) begin
                r_wcnt <= r_wcnt + WCNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        veri_pd_lane_vote #(
            .WIN      (WIN),
            .LOCK_CNT (LOCK_CNT),
            .VW       (LVW),
            .AW       (LAW)
        ) u_lane (
            .i_clk        (i_clk),
            .i_reset      (i_reset),
            .i_sample     (w_sample),
            .i_last       (w_last),
            .i_raw        (i_pd_raw[g]),
            .i_freeze_clr (i_freeze_clr),
            .o_pd_out     (o_pd_out[g]),
            .o_freeze     (o_freeze[g])
        );
    end

    assign o_win_done   = r_win_done;
    assign o_locked_all = &o_freeze;

endmodule
